// File: rtl/demux_if.sv
// Bus bundle for the 1-to-8 demux: select/data in, registered line outputs back.
interface demux_if #(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned OUT_W = 8
);
   logic [SEL_W-1:0] S;
   logic             D;
   logic [OUT_W-1:0] Do;

   modport master (
      output S,
      output D,
      input  Do
   );

   modport slave (
      input  S,
      input  D,
      output Do
   );
endinterface

// File: rtl/demux.sv
// 1-to-OUT_W demultiplexer: steers D onto line S, all other lines 0, one-cycle registered output.
module demux #(
   parameter int unsigned          SEL_W   = 3,
   parameter int unsigned          OUT_W   = 8,
   parameter logic [OUT_W-1:0]     RST_VAL = '0
) (
   input logic     clk,
   input logic     rst,
   demux_if.slave  bus
);

   if (OUT_W != (2 ** SEL_W)) begin : g_param_check
      $error("demux: OUT_W must equal 2**SEL_W");
   end

   logic [OUT_W-1:0] w_do_d;
   logic [OUT_W-1:0] r_do;

   // Shift form keeps X on S or D visible as X on the outputs in simulation.
   always_comb begin
      w_do_d = {{(OUT_W-1){1'b0}}, bus.D} << bus.S;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_do <= RST_VAL;
      end else begin
         r_do <= w_do_d;
      end
   end

   assign bus.Do = r_do;

endmodule

// File: tb/tb_demux.sv
// Table-driven, scoreboarded bench for demux: reset, walking select, data zero, random, corners.
module tb_demux;

   logic clk;
   logic rst;

   demux_if #(.SEL_W(3), .OUT_W(8)) bus ();

   demux #(
      .SEL_W   (3),
      .OUT_W   (8),
      .RST_VAL (8'h00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       d;
      logic [2:0] s;
      logic [7:0] exp;
   } vec_t;

   vec_t       tbl [16];
   logic [7:0] exp_q [$];
   logic [7:0] model_do;
   int         n_tests;
   int         n_fail;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h at %0t", name, got, req, $time);
      end
   endtask

   // Drive one input pair; Do must not move before the edge, then match the scoreboard after it.
   task automatic step(input logic d, input logic [2:0] s, input logic [7:0] req,
                       input string name);
      logic [7:0] head;
      bus.D = d;
      bus.S = s;
      exp_q.push_back(req);
      #1;
      check({name, "_no_comb"}, bus.Do, model_do);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({name, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
         head = exp_q.pop_front();
         model_do = head;
         check(name, bus.Do, head);
         check({name, "_onehot"}, {7'b0, ($countones(bus.Do) <= 1)}, 8'h01);
      end
   endtask

   initial begin
      logic       rd;
      logic [2:0] rs;
      logic [7:0] rexp;

      n_tests  = 0;
      n_fail   = 0;
      model_do = 8'h00;

      tbl[0]  = '{1'b1, 3'd0, 8'h01};
      tbl[1]  = '{1'b1, 3'd1, 8'h02};
      tbl[2]  = '{1'b1, 3'd2, 8'h04};
      tbl[3]  = '{1'b1, 3'd3, 8'h08};
      tbl[4]  = '{1'b1, 3'd4, 8'h10};
      tbl[5]  = '{1'b1, 3'd5, 8'h20};
      tbl[6]  = '{1'b1, 3'd6, 8'h40};
      tbl[7]  = '{1'b1, 3'd7, 8'h80};
      for (int i = 0; i < 8; i++) begin
         tbl[8+i] = '{1'b0, 3'(i), 8'h00};
      end

      // Reset with D=1, S=5 applied: Do clear at once and across edges.
      rst   = 1'b1;
      bus.D = 1'b1;
      bus.S = 3'd5;
      #1;
      check("reset_immediate", bus.Do, 8'h00);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("reset_held", bus.Do, 8'h00);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_release_no_edge", bus.Do, 8'h00);
      step(1'b1, 3'd5, 8'h20, "reset_first_edge");

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].d, tbl[i].s, tbl[i].exp, $sformatf("table_%0d", i));
      end

      for (int i = 0; i < 24; i++) begin
         rd   = 1'($urandom_range(0, 1));
         rs   = 3'(i % 8);
         rexp = 8'h00;
         rexp[rs] = rd;
         step(rd, rs, rexp, $sformatf("random_%0d", i));
      end

      // Mid-operation async reset pulse between edges.
      step(1'b1, 3'd6, 8'h40, "midrst_setup");
      #2;
      rst = 1'b1;
      #1;
      check("midrst_immediate", bus.Do, 8'h00);
      #1;
      rst = 1'b0;
      model_do = 8'h00;
      #1;
      check("midrst_release_no_edge", bus.Do, 8'h00);
      step(1'b1, 3'd6, 8'h40, "midrst_restore");

      // S 3->4 and D 1->0 together.
      step(1'b1, 3'd3, 8'h08, "simul_pre");
      step(1'b0, 3'd4, 8'h00, "simul_change");
      step(1'b1, 3'd7, 8'h80, "boundary_s7");
      step(1'b1, 3'd0, 8'h01, "boundary_s0");

      check("sb_drained", 8'(exp_q.size()), 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/demux.md
Name: demux

Overview:
- 1-to-8 demultiplexer with registered outputs.
- Routes a single data bit D onto one of eight output lines selected by the 3-bit select S; all unselected lines are driven 0.
- Used as a leaf utility block wherever a serial bit must be steered to one of eight destinations. Output is registered so it can feed timing-critical logic directly.

Parameters:
- SEL_W, 3, select width in bits.
- OUT_W, 8, number of output lines; must equal 2**SEL_W. Elaboration error if not.
- RST_VAL, 8'h00, value loaded into Do on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Do  output  OUT_W (8)  demultiplexed outputs, registered.
- S  input  SEL_W (3)  output line select; S=0 selects Do[0], S=7 selects Do[7].
- D  input  1  data bit to route.

Behaviour:
- Reset:
  - rst=1 asynchronously forces Do=RST_VAL (8'h00) immediately, independent of clk.
  - Do is held at RST_VAL while rst is high.
  - On the first rising clk edge after rst deasserts, normal operation resumes.
- Core function, evaluated on every rising clk edge when rst=0:
  - Do[S] <= D.
  - Do[i] <= 0 for all i != S.
  - Equivalently, Do <= {7'b0, D} << S.
- Latency:
  - Exactly one clock from D/S sampled to Do update.
  - No combinational path from D or S to Do.
- Output coding:
  - Do is one-hot (when D=1) or all-zero (when D=0).
  - Never more than one bit of Do is 1.
- No enable: Do updates every cycle.
- Boundary conditions:
  - S=3'b000: only Do[0] may be 1.
  - S=3'b111: only Do[7] may be 1. No wrap-around; S is fully decoded.
  - D=0 for any S: Do=8'h00 on the next edge.
  - S and D changing in the same cycle: both are sampled together at the edge; no glitch reaches Do.
  - rst asserted mid-stream: Do clears immediately, without waiting for a clock edge.
  - X/Z on S or D: Do goes X in simulation. Synthesis behaviour is don't-care.
- Power-up: Do is undefined until the first rst assertion. The integrating system must assert rst at power-up.

Test Plan:
- Reset: assert rst with D=1, S=5 -> Do=8'h00 immediately and while rst is held; after release, the first edge gives Do=8'b0010_0000.
- Walking select: D=1, S stepped 0..7 on successive edges -> Do one cycle later = 8'h01, 02, 04, 08, 10, 20, 40, 80.
- Data zero: D=0, S stepped 0..7 -> Do=8'h00 on every cycle.
- Random sweep: D random, S=0..7, each held one cycle -> Do == ({7'b0,D} << S) delayed by one cycle. Check one-hot/zero every cycle.
- Mid-operation reset: D=1, S=6 running (Do=8'h40), pulse rst between clock edges -> Do=8'h00 within the pulse, with no clk edge needed. After release, the next edge restores 8'h40.
- Simultaneous change: S 3->4 and D 1->0 at the same edge -> Do goes 8'h08 -> 8'h00 with no intermediate value.
